// File: rtl/prio_encoder_q.sv
// Registered priority encoder with pending set and valid/ready output.
// Issues one binary request index per accepted transfer.
module prio_encoder_q #(
   parameter int N_REQ   = 8,
   parameter int RR_MODE = 0,
   parameter int STICKY  = 1,
   localparam int IDX_W  = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [N_REQ-1:0] req_in,
   input  logic             clr_in,
   input  logic             ready_in,
   output logic             valid_out,
   output logic [IDX_W-1:0] idx_out,
   output logic [N_REQ-1:0] pending_out
);

   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] sel_oh;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] sel;
   logic             any_req;
   logic             found;
   logic             load;
   int               pos;

   // candidate set: recorded requests merged with this cycle's events
   always_comb begin
      cand = req_in;
      if (STICKY != 0) cand = pending | req_in;
      any_req = |cand;
      load    = !valid_out || ready_in;
   end

   // pick the winner: lowest index, or first index after rr_ptr
   always_comb begin
      sel   = '0;
      found = 1'b0;
      pos   = 0;
      if (RR_MODE == 0) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && cand[i]) begin
               sel   = IDX_W'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % N_REQ;
            if (!found && cand[pos]) begin
               sel   = IDX_W'(pos);
               found = 1'b1;
            end
         end
      end
      sel_oh = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
   end

   // output stage, pending set and round-robin pointer
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         valid_out <= 1'b0;
         idx_out   <= '0;
         pending   <= '0;
         rr_ptr    <= IDX_W'(N_REQ - 1);
      end else if (clr_in) begin
         valid_out <= 1'b0;
         pending   <= '0;
      end else if (load) begin
         valid_out <= any_req;
         if (any_req) begin
            idx_out <= sel;
            rr_ptr  <= sel;
         end
         if (STICKY != 0) pending <= cand & ~sel_oh;
         else             pending <= '0;
      end else begin
         if (STICKY != 0) pending <= cand;
         else             pending <= '0;
      end
   end

   assign pending_out = pending;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q: fixed, round-robin,
// non-sticky and non-power-of-2 instances share one stimulus.
module tb_prio_encoder_q;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       clr;
   logic       ready;

   logic       f_valid, r_valid, n_valid, p_valid;
   logic [2:0] f_idx, r_idx, n_idx, p_idx;
   logic [7:0] f_pend, r_pend, n_pend;
   logic [4:0] p_pend;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prio_encoder_q #(.N_REQ(8), .RR_MODE(0), .STICKY(1)) u_fix (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .clr_in(clr),
      .ready_in(ready), .valid_out(f_valid), .idx_out(f_idx),
      .pending_out(f_pend));

   prio_encoder_q #(.N_REQ(8), .RR_MODE(1), .STICKY(1)) u_rr (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .clr_in(clr),
      .ready_in(ready), .valid_out(r_valid), .idx_out(r_idx),
      .pending_out(r_pend));

   prio_encoder_q #(.N_REQ(8), .RR_MODE(0), .STICKY(0)) u_ns (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .clr_in(clr),
      .ready_in(ready), .valid_out(n_valid), .idx_out(n_idx),
      .pending_out(n_pend));

   prio_encoder_q #(.N_REQ(5), .RR_MODE(1), .STICKY(1)) u_p5 (
      .clk_in(clk), .rst_n_in(rst_n), .req_in(req[4:0]), .clr_in(clr),
      .ready_in(ready), .valid_out(p_valid), .idx_out(p_idx),
      .pending_out(p_pend));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset dominates active requests
      rst_n = 1'b0; req = 8'hFF; ready = 1'b1; clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_valid", 32'(f_valid), 0);
         chk("rst_idx", 32'(f_idx), 0);
         chk("rst_pend", 32'(f_pend), 0);
      end
      rst_n = 1'b1;
      step();
      chk("rel_valid", 32'(f_valid), 1);
      chk("rel_idx", 32'(f_idx), 0);
      chk("rel_pend", 32'(f_pend), 32'hFE);
      chk("rel_rr_idx", 32'(r_idx), 0);
      chk("rel_ns_pend", 32'(n_pend), 0);
      clr = 1'b1; req = 8'h00;
      step();
      clr = 1'b0;

      // 2: pulse A4 drains as 2, 5, 7
      req = 8'hA4;
      step();
      chk("a4_idx0", 32'(f_idx), 2);
      chk("a4_pend0", 32'(f_pend), 32'hA0);
      req = 8'h00;
      step();
      chk("a4_idx1", 32'(f_idx), 5);
      chk("a4_pend1", 32'(f_pend), 32'h80);
      step();
      chk("a4_idx2", 32'(f_idx), 7);
      chk("a4_valid2", 32'(f_valid), 1);
      chk("a4_pend2", 32'(f_pend), 0);
      step();
      chk("a4_valid3", 32'(f_valid), 0);
      chk("a4_idx3", 32'(f_idx), 7);

      // 3: backpressure holds output, records new request
      ready = 1'b0; req = 8'h01;
      step();
      chk("bp_idx0", 32'(f_idx), 0);
      chk("bp_valid0", 32'(f_valid), 1);
      req = 8'h80;
      step();
      chk("bp_idx1", 32'(f_idx), 0);
      chk("bp_pend1", 32'(f_pend), 32'h80);
      req = 8'h00;
      step();
      chk("bp_idx2", 32'(f_idx), 0);
      chk("bp_pend2", 32'(f_pend), 32'h80);
      ready = 1'b1;
      step();
      chk("bp_idx3", 32'(f_idx), 7);
      chk("bp_valid3", 32'(f_valid), 1);
      chk("bp_pend3", 32'(f_pend), 0);
      step();
      chk("bp_valid4", 32'(f_valid), 0);

      // 4: held 0F, round-robin rotates, fixed starves
      do_reset();
      req = 8'h0F;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr_idx", 32'(r_idx), 32'(i % 4));
         chk("fix_idx", 32'(f_idx), 0);
         chk("fix_pend", 32'(f_pend), 32'h0E);
      end

      // 4b: N_REQ=5 round-robin wraps 4 -> 0
      do_reset();
      req = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("p5_idx", 32'(p_idx), 32'(i % 5));
      end

      // 5: clear drops pending, output and same-cycle request
      do_reset();
      ready = 1'b0; req = 8'h01;
      step();
      req = 8'h30;
      step();
      chk("clr_pre_pend", 32'(f_pend), 32'h30);
      chk("clr_pre_valid", 32'(f_valid), 1);
      clr = 1'b1; req = 8'h01;
      step();
      chk("clr_valid", 32'(f_valid), 0);
      chk("clr_pend", 32'(f_pend), 0);
      chk("clr_idx", 32'(f_idx), 0);
      clr = 1'b0; req = 8'h00; ready = 1'b1;
      step();
      chk("clr_drop_valid", 32'(f_valid), 0);
      chk("clr_drop_pend", 32'(f_pend), 0);

      // 6: non-sticky drops unserved request
      do_reset();
      ready = 1'b0; req = 8'h06;
      step();
      chk("ns_idx0", 32'(n_idx), 1);
      chk("ns_valid0", 32'(n_valid), 1);
      chk("ns_pend0", 32'(n_pend), 0);
      req = 8'h00;
      step();
      chk("ns_idx1", 32'(n_idx), 1);
      chk("ns_pend1", 32'(n_pend), 0);
      ready = 1'b1;
      step();
      chk("ns_valid2", 32'(n_valid), 0);
      chk("ns_idx2", 32'(n_idx), 1);
      step();
      chk("ns_valid3", 32'(n_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
